// File: rtl/seg_scan_ctrl_pkg.sv
// Shared constants for the 8-digit seven-segment scan controller.
package seg_scan_ctrl_pkg;
    localparam int NUM_DIGITS = 8;
    localparam int SEL_W      = 3;
    localparam int SEG_W      = 7;

    localparam logic [SEG_W-1:0]      SEG_BLANK = 7'h7F;
    localparam logic [NUM_DIGITS-1:0] AN_OFF    = 8'hFF;
endpackage

// File: rtl/seg_scan_ctrl_prescaler.sv
// Digit-slot counter: runs 0..CLK_DIV-1, cleared while the scan is parked,
// and decodes the slot-end, blanking and dimming windows.
module scan_prescaler #(
    parameter int CLK_DIV      = 50000,
    parameter int BLANK_CYCLES = 500
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic dim,
    output logic slot_end,
    output logic blank,
    output logic dim_cut
);
    localparam int CNT_W = $clog2(CLK_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYCLES);
    localparam logic [CNT_W-1:0] CNT_DIM   = CNT_W'(BLANK_CYCLES + (CLK_DIV - BLANK_CYCLES) / 2);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign slot_end = (cnt_q == CNT_LAST);
    assign blank    = (cnt_q < CNT_BLANK);
    assign dim_cut  = dim && (cnt_q >= CNT_DIM);

    always_comb begin
        // NOTE: default assignment first so no path through this block infers a latch.
        cnt_d = cnt_q + CNT_W'(1);
        if (clr || slot_end) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            // NOTE: non-blocking assignment keeps every flop sampling pre-edge values.
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed scan controller for an 8-digit active-low 7-segment display.
// Optional SEG_SCAN_DIM_EN adds a dim input that halves the lit part of each slot.
module seg_scan_ctrl
    import seg_scan_ctrl_pkg::*;
#(
    parameter int CLK_DIV      = 50000,
    parameter int BLANK_CYCLES = 500
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
`ifdef SEG_SCAN_DIM_EN
    input  logic                  dim,
`endif
    input  logic [NUM_DIGITS-1:0] digit_mask,
    input  logic [SEG_W-1:0]      seg_in,
    output logic [SEL_W-1:0]      sel,
    output logic [NUM_DIGITS-1:0] an_n,
    output logic [SEG_W-1:0]      seg_n,
    output logic                  frame_tick
);
    localparam logic [NUM_DIGITS-1:0] AN_ONE  = NUM_DIGITS'(1);
    localparam logic [SEL_W-1:0]      SEL_TOP = SEL_W'(NUM_DIGITS - 1);

    logic                  dim_in;
    logic                  slot_end, blank, dim_cut, lit;
    logic [SEL_W-1:0]      sel_q, sel_d;
    logic [NUM_DIGITS-1:0] an_n_q, an_n_d;
    logic [SEG_W-1:0]      seg_n_q, seg_n_d;
    logic                  frame_tick_q, frame_tick_d;

`ifdef SEG_SCAN_DIM_EN
    assign dim_in = dim;
`else
    assign dim_in = 1'b0;
`endif

    scan_prescaler #(
        .CLK_DIV      (CLK_DIV),
        .BLANK_CYCLES (BLANK_CYCLES)
    ) u_prescaler (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (!en),
        .dim      (dim_in),
        .slot_end (slot_end),
        .blank    (blank),
        .dim_cut  (dim_cut)
    );

    // The last count is dark too, so the registered output never lights the
    // old digit during the first cycle after sel has moved on.
    assign lit = en && !blank && !slot_end && !dim_cut && digit_mask[sel_q];

    always_comb begin
        sel_d = sel_q;
        if (!en) begin
            sel_d = '0;
        end else if (slot_end) begin
            sel_d = sel_q + SEL_W'(1);
        end
        frame_tick_d = en && slot_end && (sel_q == SEL_TOP);
        an_n_d       = lit ? ~(AN_ONE << sel_q) : AN_OFF;
        seg_n_d      = lit ? seg_in : SEG_BLANK;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_q        <= '0;
            an_n_q       <= AN_OFF;
            seg_n_q      <= SEG_BLANK;
            frame_tick_q <= 1'b0;
        end else begin
            sel_q        <= sel_d;
            an_n_q       <= an_n_d;
            seg_n_q      <= seg_n_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    assign sel        = sel_q;
    assign an_n       = an_n_q;
    assign seg_n      = seg_n_q;
    assign frame_tick = frame_tick_q;
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with CLK_DIV=8, BLANK_CYCLES=2.
module tb_seg_scan_ctrl;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic       dim;
    logic [7:0] digit_mask;
    logic [6:0] seg_in;
    logic [2:0] sel;
    logic [7:0] an_n;
    logic [6:0] seg_n;
    logic       frame_tick;

    int total = 0;
    int bad   = 0;
    int k     = 0;  // clock edges since en was raised

    always #5 clk = ~clk;

    seg_scan_ctrl #(
        .CLK_DIV      (8),
        .BLANK_CYCLES (2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
`ifdef SEG_SCAN_DIM_EN
        .dim        (dim),
`endif
        .digit_mask (digit_mask),
        .seg_in     (seg_in),
        .sel        (sel),
        .an_n       (an_n),
        .seg_n      (seg_n),
        .frame_tick (frame_tick)
    );

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s at k=%0d: got %h expected %h", tag, k, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Park the scan for one edge, then start a fresh slot 0.
    task automatic restart();
        en = 1'b0;
        tick();
        check("idle_an", an_n, 8'hFF);
        check("idle_seg", {1'b0, seg_n}, 8'h7F);
        check("idle_sel", {5'd0, sel}, 8'h00);
        en = 1'b1;
        k  = 0;
    endtask

    // Output after edge k reflects slot position p of digit d: dark for p=0,1
    // (blanking) and p=7 (slot end), lit for p=2..6 (p=2..4 when dimmed).
    task automatic run(input int n);
        int p, d, hi;
        logic       lit;
        logic [7:0] one, exp_an;
        logic [6:0] exp_seg;
        for (int i = 0; i < n; i++) begin
            tick();
            k++;
            p   = (k - 1) % 8;
            d   = ((k - 1) / 8) % 8;
            hi  = dim ? 4 : 6;
            lit = (p >= 2) && (p <= hi) && digit_mask[d];
            one = 8'h01;
            exp_an  = lit ? ~(one << d) : 8'hFF;
            exp_seg = lit ? seg_in : 7'h7F;
            check("an_n", an_n, exp_an);
            check("seg_n", {1'b0, seg_n}, {1'b0, exp_seg});
            check("sel", {5'd0, sel}, 8'((k / 8) % 8));
            check("frame_tick", {7'd0, frame_tick}, {7'd0, (k % 64) == 0});
        end
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n      = 1'b0;
        en         = 1'b0;
        dim        = 1'b0;
        digit_mask = 8'hFF;
        seg_in     = 7'h40;

        #12;
        check("rst_an", an_n, 8'hFF);
        check("rst_seg", {1'b0, seg_n}, 8'h7F);
        check("rst_sel", {5'd0, sel}, 8'h00);
        check("rst_tick", {7'd0, frame_tick}, 8'h00);
        #10 rst_n = 1'b1;

        // Full scan, two frames
        restart();
        run(128);

        // Odd digits only; even slots stay dark but keep their time
        digit_mask = 8'b1010_1010;
        restart();
        run(64);

        // Drop enable mid-SHOW of digit 3, then restart
        digit_mask = 8'hFF;
        restart();
        run(29);
        restart();
        run(3);
        check("restart_first_lit", an_n, 8'hFE);

        // seg_in change mid-SHOW of digit 2
        seg_in = 7'h79;
        restart();
        run(20);
        seg_in = 7'h24;
        run(1);
        check("follow_an", an_n, 8'hFB);
        check("follow_seg", {1'b0, seg_n}, 8'h24);
        run(3);

`ifdef SEG_SCAN_DIM_EN
        dim = 1'b1;
        restart();
        run(24);
        dim = 1'b0;
        run(16);
`endif

        // Async reset mid-SHOW with digit 0 lit
        seg_in = 7'h40;
        restart();
        run(4);
        check("pre_rst_an", an_n, 8'hFE);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_an", an_n, 8'hFF);
        check("async_rst_seg", {1'b0, seg_n}, 8'h7F);
        check("async_rst_sel", {5'd0, sel}, 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
